// File: rtl/invader_hit_detect.sv
// Per-frame bullet/invader collision check: locates the grid cell by repeated
// subtraction, tests the sprite box and alive bit, and masks the last two reported hits.
module invader_hit_detect #(
    parameter int COLS     = 11,
    parameter int ROWS     = 5,
    parameter int CELL_W   = 32,
    parameter int CELL_H   = 32,
    parameter int SPRITE_W = 24,
    parameter int SPRITE_H = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 bullet_active,
    input  logic [9:0]           bullet_x,
    input  logic [9:0]           bullet_y,
    input  logic [COLS*ROWS-1:0] invaders,
    input  logic [9:0]           invaders_x,
    input  logic [9:0]           invaders_y,
    output logic [5:0]           invader_collision,
    output logic                 hit_valid,
    output logic [5:0]           score_pts,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, SNAP, DIVX, DIVY, CHECK, DONE} state_t;

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [10:0]   GRID_W  = 11'(COLS * CELL_W);
    localparam logic [10:0]   GRID_H  = 11'(ROWS * CELL_H);
    localparam logic [10:0]   CELL_WL = 11'(CELL_W);
    localparam logic [10:0]   CELL_HL = 11'(CELL_H);
    localparam logic [10:0]   SPR_WL  = 11'(SPRITE_W);
    localparam logic [10:0]   SPR_HL  = 11'(SPRITE_H);
    localparam logic [5:0]    NCOLS   = 6'(COLS);
    localparam logic [RW-1:0] ROW_MID = RW'(3);

    state_t                state_q, state_d;
    logic                  act_q, act_d;
    logic [9:0]            bx_q, bx_d, by_q, by_d, gx_q, gx_d, gy_q, gy_d;
    logic [COLS*ROWS-1:0]  inv_q, inv_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [10:0]           rx_q, rx_d, ry_q, ry_d;
    logic [5:0]            result_q, result_d;
    logic [5:0]            mask0_q, mask0_d, mask1_q, mask1_d;
    logic [5:0]            coll_q, coll_d, score_q, score_d;
    logic                  hit_q, hit_d;

    logic [10:0] dx, dy;
    logic        outOfGrid;
    logic [5:0]  idx, idxP1;
    logic        hit;

    // Zero-extended subtraction keeps a grid near 1023 from aliasing a wrapped bullet.
    assign dx        = {1'b0, bx_q} - {1'b0, gx_q};
    assign dy        = {1'b0, by_q} - {1'b0, gy_q};
    assign outOfGrid = !act_q || dx[10] || dy[10] || (dx >= GRID_W) || (dy >= GRID_H);
    assign idx       = 6'(row_q) * NCOLS + 6'(col_q);
    assign idxP1     = idx + 6'd1;
    assign hit       = (rx_q < SPR_WL) && (ry_q < SPR_HL) && inv_q[idx]
                     && !((mask0_q != '0) && (mask0_q == idxP1))
                     && !((mask1_q != '0) && (mask1_q == idxP1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            act_q    <= 1'b0;
            bx_q     <= '0;
            by_q     <= '0;
            gx_q     <= '0;
            gy_q     <= '0;
            inv_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            result_q <= '0;
            mask0_q  <= '0;
            mask1_q  <= '0;
            coll_q   <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            inv_q    <= inv_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            result_q <= result_d;
            mask0_q  <= mask0_d;
            mask1_q  <= mask1_d;
            coll_q   <= coll_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
        end
    end

    // A frame in any state restarts from a fresh snapshot, discarding a check in flight.
    always_comb begin
        state_d = state_q;
        if (frame) begin
            state_d = SNAP;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SNAP:    state_d = outOfGrid ? DONE : DIVX;
                DIVX:    if (rx_q < CELL_WL) state_d = DIVY;
                DIVY:    if (ry_q < CELL_HL) state_d = CHECK;
                CHECK:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        act_d    = act_q;
        bx_d     = bx_q;
        by_d     = by_q;
        gx_d     = gx_q;
        gy_d     = gy_q;
        inv_d    = inv_q;
        col_d    = col_q;
        row_d    = row_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        result_d = result_q;
        mask0_d  = mask0_q;
        mask1_d  = mask1_q;
        coll_d   = coll_q;
        score_d  = score_q;
        hit_d    = 1'b0;
        if (frame) begin
            act_d = bullet_active;
            bx_d  = bullet_x;
            by_d  = bullet_y;
            gx_d  = invaders_x;
            gy_d  = invaders_y;
            inv_d = invaders;
        end else begin
            case (state_q)
                SNAP: begin
                    if (outOfGrid) begin
                        result_d = '0;
                    end else begin
                        col_d = '0;
                        rx_d  = dx;
                    end
                end
                DIVX: begin
                    if (rx_q >= CELL_WL) begin
                        rx_d  = rx_q - CELL_WL;
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d = '0;
                        ry_d  = dy;
                    end
                end
                DIVY: begin
                    if (ry_q >= CELL_HL) begin
                        ry_d  = ry_q - CELL_HL;
                        row_d = row_q + 1'b1;
                    end
                end
                CHECK: result_d = hit ? idxP1 : 6'd0;
                DONE: begin
                    coll_d  = result_q;
                    mask1_d = mask0_q;
                    mask0_d = result_q;
                    if (result_q != '0) begin
                        hit_d = 1'b1;
                        if (row_q == '0)          score_d = 6'd30;
                        else if (row_q < ROW_MID) score_d = 6'd20;
                        else                      score_d = 6'd10;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy              = (state_q != IDLE);
        invader_collision = coll_q;
        hit_valid         = hit_q;
        score_pts         = score_q;
    end

endmodule

// File: tb/tb_invader_hit_detect.sv
// Scoreboard bench for invader_hit_detect: a division-based reference model predicts
// each completed check; a monitor pops predictions whenever busy falls.
module tb_invader_hit_detect;

    localparam int COLS = 11, ROWS = 5, CELL_W = 32, CELL_H = 32, SPR_W = 24, SPR_H = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        bullet_active = 1'b0;
    logic [9:0]  bullet_x = '0, bullet_y = '0, invaders_x = '0, invaders_y = '0;
    logic [54:0] invaders = '0;
    logic [5:0]  invader_collision, score_pts;
    logic        hit_valid, busy;

    invader_hit_detect dut (
        .clk(clk), .rst(rst), .frame(frame), .bullet_active(bullet_active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .invaders(invaders),
        .invaders_x(invaders_x), .invaders_y(invaders_y),
        .invader_collision(invader_collision), .hit_valid(hit_valid),
        .score_pts(score_pts), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int coll;
        int hv;
        int score;
        int lat;
        int start;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   m0 = 0, m1 = 0, lastScore = 0, lastColl = 0;
    bit   prevBusy = 1'b0, chkPulse = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: cell located by integer division, hit masked against the last two reports.
    function automatic exp_t modelPredict(input bit act, input int bx, input int by,
                                          input int gx, input int gy, input logic [54:0] inv);
        exp_t e;
        int dx, dy, col, row, rx, ry, idx;
        dx = bx - gx;
        dy = by - gy;
        e.coll = 0; e.hv = 0; e.score = lastScore; e.lat = 2; e.start = 0;
        if (act && dx >= 0 && dy >= 0 && dx < COLS * CELL_W && dy < ROWS * CELL_H) begin
            col = dx / CELL_W; rx = dx % CELL_W;
            row = dy / CELL_H; ry = dy % CELL_H;
            e.lat = col + row + 5;
            idx = row * COLS + col;
            if (rx < SPR_W && ry < SPR_H && inv[idx] == 1'b1 && idx + 1 != m0 && idx + 1 != m1) begin
                e.coll  = idx + 1;
                e.hv    = 1;
                e.score = (row == 0) ? 30 : (row <= 2) ? 20 : 10;
            end
        end
        m1 = m0; m0 = e.coll; lastScore = e.score; lastColl = e.coll;
        return e;
    endfunction

    task automatic applyStimulus(input bit act, input int bx, input int by, input int gx,
                                 input int gy, input logic [54:0] inv, input bit track);
        exp_t e;
        @(negedge clk);
        bullet_active = act;
        bullet_x = 10'(bx); bullet_y = 10'(by);
        invaders_x = 10'(gx); invaders_y = 10'(gy);
        invaders = inv;
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        checkOutput("collision_hold", int'(invader_collision), lastColl);
        if (track) begin
            e = modelPredict(act, bx & 1023, by & 1023, gx & 1023, gy & 1023, inv);
            e.start = cyc;
            sb.push_back(e);
        end
        bullet_active = 1'($urandom);
        bullet_x = 10'($urandom); bullet_y = 10'($urandom);
        invaders = 55'({$urandom, $urandom});
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("completion_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chkPulse) begin
            checkOutput("hit_valid_width", int'(hit_valid), 0);
            chkPulse = 1'b0;
        end
        if (!rst && prevBusy && !busy) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_completion", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("invader_collision", int'(invader_collision), e.coll);
                checkOutput("hit_valid", int'(hit_valid), e.hv);
                checkOutput("score_pts", int'(score_pts), e.score);
                checkOutput("latency", cyc - e.start, e.lat);
                chkPulse = 1'b1;
            end
        end
        prevBusy = busy;
    end

    logic [54:0] allAlive, noBit13, bit0Only, rndInv;
    int gx, gy, bx, by;

    initial begin
        allAlive = '1;
        noBit13  = '1; noBit13[13] = 1'b0;
        bit0Only = '0; bit0Only[0] = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_collision", int'(invader_collision), 0);
        checkOutput("reset_hit_valid", int'(hit_valid), 0);
        checkOutput("reset_score", int'(score_pts), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b0;

        applyStimulus(1, 169, 115, 100, 80, allAlive, 1); waitIdle();
        applyStimulus(1, 126, 85, 100, 80, allAlive, 1);  waitIdle();
        applyStimulus(1, 169, 115, 100, 80, noBit13, 1);  waitIdle();
        applyStimulus(1, 100, 80, 100, 80, bit0Only, 1);  waitIdle();
        applyStimulus(1, 99, 80, 100, 80, allAlive, 1);   waitIdle();
        applyStimulus(1, 100, 79, 100, 80, allAlive, 1);  waitIdle();
        applyStimulus(1, 452, 80, 100, 80, allAlive, 1);  waitIdle();
        applyStimulus(0, 169, 115, 100, 80, allAlive, 1); waitIdle();
        applyStimulus(1, 5, 85, 1000, 80, allAlive, 1);   waitIdle();

        // Bitmap lags one frame behind the kill, so repeats of 14 must be masked.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 169, 115, 100, 80, allAlive, 1);
            waitIdle();
        end

        applyStimulus(1, 451, 239, 100, 80, allAlive, 1); waitIdle();

        // Abort a worst-case check mid-flight; only the restarted one reports.
        applyStimulus(1, 451, 239, 100, 80, allAlive, 0);
        repeat (4) @(negedge clk);
        applyStimulus(1, 425, 213, 100, 80, allAlive, 1);
        waitIdle();

        applyStimulus(1, 425, 213, 100, 80, allAlive, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_collision", int'(invader_collision), 0);
        checkOutput("rst_mid_hit_valid", int'(hit_valid), 0);
        checkOutput("rst_mid_score", int'(score_pts), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        sb.delete();
        m0 = 0; m1 = 0; lastScore = 0; lastColl = 0;
        @(negedge clk);
        #2 rst = 1'b0;

        bx = 0; by = 0; gx = 0; gy = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 0 || $urandom_range(0, 3) != 0) begin
                gx = ($urandom_range(0, 9) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 700);
                gy = $urandom_range(0, 500);
                bx = (gx + $urandom_range(0, 372) - 10) & 1023;
                by = (gy + $urandom_range(0, 180) - 10) & 1023;
            end
            rndInv = 55'({$urandom, $urandom}) | 55'({$urandom, $urandom});
            applyStimulus($urandom_range(0, 7) != 0, bx, by, gx, gy, rndInv, 1);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/invader_hit_detect.md
# invader_hit_detect

Per-frame collision checker between the player bullet and the invader grid. It sits directly upstream of the invaders block. It produces the 1-based `invader_collision` index that block consumes on its `frame` cycle, plus a bullet-kill pulse and a score increment. Each check is a short multi-cycle FSM launched by `frame`. It runs well inside the blanking interval and does not use a combinational divider.

## Interface
Parameters:
- `COLS`, 11, grid columns
- `ROWS`, 5, grid rows
- `CELL_W`, 32, horizontal pitch in pixels
- `CELL_H`, 32, vertical pitch in pixels
- `SPRITE_W`, 24, hittable width from the cell's left edge (≤ `CELL_W`)
- `SPRITE_H`, 16, hittable height from the cell's top edge (≤ `CELL_H`)

Ports:
- `clk` in 1: clock clk
- `rst` in 1: reset rst, asynchronous, active-high
- `frame` in 1: one-cycle pulse at start of blanking
- `bullet_active` in 1: player bullet in flight
- `bullet_x`, `bullet_y` in 10 each: bullet tip pixel
- `invaders` in 55: alive bitmap, bit `row*COLS+col`
- `invaders_x`, `invaders_y` in 10 each: grid top-left corner
- `invader_collision` out 6: 1-based hit index, 0 = none
- `hit_valid` out 1: one-cycle pulse when a check finds a hit
- `score_pts` out 6: points for the hit; valid with `hit_valid`, held afterwards
- `busy` out 1: check in progress

## Operation
FSM states: IDLE, SNAP, DIVX, DIVY, CHECK, DONE.

- **IDLE**, on `frame`: register all inputs as a snapshot, go to SNAP.
- **SNAP**:
  - dx = bx − gx, dy = by − gy, each 11-bit signed.
  - If the bullet is inactive, dx < 0, dy < 0, dx ≥ `COLS*CELL_W`, or dy ≥ `ROWS*CELL_H`: set result = 0 and go to DONE.
  - Otherwise go to DIVX with col = 0 and rx = dx.
- **DIVX**: while rx ≥ `CELL_W`, do rx −= `CELL_W` and col++ (one per cycle). When done, go to DIVY with row = 0 and ry = dy.
- **DIVY**: same procedure with `CELL_H`, producing row and ry.
- **CHECK**:
  - idx = row*`COLS` + col.
  - Hit when all of the following hold: rx < `SPRITE_W`; ry < `SPRITE_H`; snapshot bit idx = 1; idx+1 is not in the mask.
  - On hit, result = idx+1; otherwise result = 0.
- **DONE**:
  - Load `invader_collision` ← result.
  - If result ≠ 0: pulse `hit_valid`; set `score_pts` = 30 for row 0, 20 for rows 1–2, 10 for rows 3–4.
  - Shift the mask: mask1 ← mask0, mask0 ← result.
  - Return to IDLE.

Mask:
- Purpose: the invaders block applies a kill at frame N+1, and the bitmap seen here still shows that invader alive for the checks started at frames N+1 and N+2. The last two reported indices are therefore treated as dead.
- Masking checks only nonzero values.

`invader_collision` behaviour:
- Changes only in DONE.
- Holds across the next `frame` cycle, so the consumer samples each result exactly once.

## Timing
- Reset values: `invader_collision` = 0, `hit_valid` = 0, `score_pts` = 0, `busy` = 0, mask = {0,0}, state IDLE.
- `busy` is high from the cycle after `frame` until DONE, inclusive.
- Latency from `frame` to the `invader_collision` update:
  - out-of-grid or inactive bullet: 2 cycles (SNAP, DONE);
  - worst case: 1 + `COLS` + `ROWS` + 2 = 19 cycles.
- `frame` while busy: abort the check. No output or mask update. Re-snapshot and restart at SNAP next cycle.
- `rst` mid-check: immediate return to reset values.
- Arithmetic:
  - col saturates at `COLS`−1, row at `ROWS`−1 (guaranteed by the SNAP bounds check).
  - Indices are 6-bit unsigned; maximum is 55.
- Wrap-around: none. A grid x near 1023 with dx negative is out of grid, never an aliased hit.

## Test plan
- Grid (100,80), all alive, bullet (169,115) active, `frame` → after DONE: `invader_collision` = 14, `hit_valid` pulses once, `score_pts` = 20.
- Grid (100,80), bullet (126,85), i.e. rx = 26 in the inter-sprite gap → `invader_collision` = 0, no `hit_valid`.
- Same hit as test 1 with bit 13 cleared → 0. With bullet (100,80) and bit 0 set → 1, `score_pts` = 30.
- Bullet (99,80), (100,79), (452,80), and an inactive bullet → each returns 0 in 2 cycles.
- Bullet fixed at (169,115) across three frames while the bitmap updates one frame late → results 14, 0, 0; second `frame` sees `invader_collision` = 14 stable.
- `frame` pulsed 5 cycles into a worst-case check (bullet (452−1,239)) → first check discarded, restarted result 55 at about 19 cycles. `rst` asserted mid-DIVX → all outputs 0 at once.
